matrix_mult_seq: RTL
====================

// Module: matrix_mult_seq
// PURPOSE
//   Parametrised NxN matrix multiplier: m_out = m1 * m2, one result element per cycle.
//   Successor to the fixed 4x4 combinational multiplier in the CPU datapath.
//   Adds a ready/valid handshake, signed/unsigned operands, wrap/saturate modes and an overflow flag.
//   Sits between the register file / matrix memory and the writeback bus.
// PARAMETERS
//   N    4   matrix dimension (N x N), N >= 2
//   DW   16  element width in bits
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   enable     in   1        global advance; low = every register holds
//   in_valid   in   1        m1/m2/mode valid
//   in_ready   out  1        block can accept operands (high only in IDLE)
//   mode       in   2        [0] 1=signed operands; [1] 1=saturate, 0=wrap
//   m1         in   N*N*DW   matrix A, element [r][c] at bits (r*N+c)*DW +: DW
//   m2         in   N*N*DW   matrix B, same layout
//   out_valid  out  1        m_out/out_ovf valid
//   out_ready  in   1        consumer takes the result
//   m_out      out  N*N*DW   result C, same layout
//   out_ovf    out  1        at least one element overflowed DW (wrapped or clamped)
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, out_ovf=0, m_out=0, idx=0.
//   enable=0: no state, index or data register changes; the handshake is not sampled.
//   FSM (all transitions require enable=1):
//     IDLE -> CALC on in_valid&&in_ready. Latch m1, m2, mode. Clear idx, out_ovf, m_out.
//     CALC: on each edge write C[idx/N][idx%N] = sum_k A[r][k]*B[k][c], then idx++.
//       After writing idx=N*N-1 -> DONE; out_valid=1.
//     DONE: hold m_out and out_ovf. On out_ready -> IDLE; out_valid=0.
//   Latency: out_valid rises exactly N*N enabled cycles after the accept edge.
//   Throughput: one bubble cycle (IDLE) between results; in_ready=0 in CALC and DONE.
//   Inputs m1/m2/mode may change after acceptance with no effect.
//   in_valid outside IDLE is ignored (not queued).
//   Arithmetic:
//     products are 2*DW wide; sums are 2*DW+clog2(N) wide with no internal overflow.
//     Operands are signed or unsigned per the latched mode[0].
//   Output per element:
//     wrap: low DW bits; ovf if the sum does not fit DW under the chosen signedness.
//     saturate, unsigned: clamp to 2^DW-1.
//     saturate, signed: clamp to [-2^(DW-1), 2^(DW-1)-1].
//     out_ovf = OR of all per-element ovf bits; it is sticky for the job.
//   Reset mid-CALC or mid-DONE: abort the job and apply the reset values on the next edge.
//     No partial result is presented.
//   reset has priority over enable, the handshake and the FSM.
// STRUCTURE
//   matrix_pkg: MODE_SIGNED/MODE_SAT bit indices, state encoding (IDLE/CALC/DONE),
//     and the elem_lsb(r,c,N,DW) index function shared by the RTL and benches.
//   Sub-module dot_product #(N,DW): combinational N-lane multiply plus adder tree.
//     Inputs: row, column and signed flag. Output: a 2*DW+clog2(N) sum.
//   Top level holds the FSM, idx counter, operand latches, wrap/saturate logic and m_out registers.
// TESTING
//   1. N=4, DW=16, mode=00.
//      A = {5,8,9,2; 7,3,8,4; 6,5,4,3; 8,5,7,6}
//      B = {11,14,19,18; 6,9,3,5; 12,10,15,14; 1,3,5,7}
//      -> C = {213,238,264,270; 195,217,282,281; 147,178,204,210; 208,245,302,309}
//      -> out_valid 16 cycles after accept; out_ovf=0.
//   2. All elements 16'hFFFF:
//      mode=10 -> every element 16'hFFFF, out_ovf=1.
//      mode=00 -> every element 16'h0004, out_ovf=1.
//      mode=01 -> every element 16'h0004 (-1*-1*4), out_ovf=0.
//   3. All elements 16'h8000, mode=11 -> every element 16'h7FFF, out_ovf=1.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//      -> m_out/out_valid stable; in_ready=0; a new in_valid is ignored.
//      Then release -> IDLE; the next job is accepted one cycle later.
//   5. Assert reset at CALC idx=7.
//      -> next cycle IDLE, m_out=0, out_valid=0, in_ready=1.
//      Rerun test 1 -> correct result.
//   6. Toggle enable low for 3 cycles mid-CALC and change m1 after accept.
//      -> result identical to test 1; latency = 16 + 3 cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix multiplier: mode bits, FSM
// encoding and the flat-vector element index helper.
package matrix_pkg;

   localparam int MODE_SIGNED = 0;
   localparam int MODE_SAT    = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Element [r][c] of an n x n matrix of dw-bit elements, row-major.
   function automatic int elem_lsb(input int r, input int c, input int n, input int dw);
      return (r * n + c) * dw;
   endfunction

endpackage

// File: rtl/dot_product.sv
// Combinational N-lane dot product of one row and one column; operands are
// treated as signed or unsigned according to is_signed.
module dot_product #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int SW = 2 * DW + $clog2(N)
) (
   input  logic [N*DW-1:0] row,
   input  logic [N*DW-1:0] col,
   input  logic            is_signed,
   output logic [SW-1:0]   sum
);

   logic signed [DW:0]     a_x;
   logic signed [DW:0]     b_x;
   logic signed [2*DW+1:0] prod;
   logic [SW-1:0]          acc;

   // One extra operand bit lets a single signed multiplier serve both modes;
   // the sum only has to be correct modulo 2^SW, since the true result fits.
   always_comb begin
      a_x  = '0;
      b_x  = '0;
      prod = '0;
      acc  = '0;
      for (int k = 0; k < N; k++) begin
         a_x  = $signed({is_signed & row[k*DW+DW-1], row[k*DW +: DW]});
         b_x  = $signed({is_signed & col[k*DW+DW-1], col[k*DW +: DW]});
         prod = (2*DW+2)'(a_x) * (2*DW+2)'(b_x);
         acc  = acc + SW'(prod);
      end
      sum = acc;
   end

endmodule

// File: rtl/matrix_mult_seq.sv
// NxN matrix multiplier producing one result element per enabled cycle,
// with ready/valid handshakes, signed/unsigned operands and wrap/saturate.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   CALC  | writing C[idx], one element per enabled edge
//   DONE  | out_valid high, holding result until out_ready
module matrix_mult_seq
   import matrix_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        mode,
   input  logic [N*N*DW-1:0] m1,
   input  logic [N*N*DW-1:0] m2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*DW-1:0] m_out,
   output logic              out_ovf
);

   localparam int NN = N * N;
   localparam int IW = $clog2(NN);
   localparam int SW = 2 * DW + $clog2(N);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NN*DW-1:0]  a_q, a_d;
   logic [NN*DW-1:0]  b_q, b_d;
   logic [1:0]        mode_q, mode_d;
   logic [NN*DW-1:0]  m_out_q, m_out_d;
   logic              ovf_q, ovf_d;

   int                row_i;
   int                col_i;
   logic [N*DW-1:0]   row_vec;
   logic [N*DW-1:0]   col_vec;
   logic [SW-1:0]     sum;
   logic [DW-1:0]     elem_val;
   logic              elem_ovf;

   always_comb begin
      row_i   = int'(idx_q) / N;
      col_i   = int'(idx_q) % N;
      row_vec = a_q[row_i*N*DW +: N*DW];
      col_vec = '0;
      for (int k = 0; k < N; k++) begin
         col_vec[k*DW +: DW] = b_q[elem_lsb(k, col_i, N, DW) +: DW];
      end
   end

   dot_product #(.N(N), .DW(DW), .SW(SW)) u_dot (
      .row       (row_vec),
      .col       (col_vec),
      .is_signed (mode_q[MODE_SIGNED]),
      .sum       (sum)
   );

   // A signed sum fits DW bits when everything from bit DW-1 up is a pure sign extension.
   always_comb begin
      elem_val = sum[DW-1:0];
      if (mode_q[MODE_SIGNED]) begin
         elem_ovf = ~((&sum[SW-1:DW-1]) | ~(|sum[SW-1:DW-1]));
      end else begin
         elem_ovf = |sum[SW-1:DW];
      end
      if (elem_ovf && mode_q[MODE_SAT]) begin
         if (mode_q[MODE_SIGNED]) begin
            elem_val = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         end else begin
            elem_val = '1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      m_out_d = m_out_q;
      ovf_d   = ovf_q;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_d = CALC;
                  a_d     = m1;
                  b_d     = m2;
                  mode_d  = mode;
                  idx_d   = '0;
                  ovf_d   = 1'b0;
                  m_out_d = '0;
               end
            end
            CALC: begin
               m_out_d[int'(idx_q)*DW +: DW] = elem_val;
               ovf_d = ovf_q | elem_ovf;
               if (idx_q == IW'(NN - 1)) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= '0;
         m_out_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         m_out_q <= m_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign m_out     = m_out_q;
   assign out_ovf   = ovf_q;

endmodule
